iob_pwm_rom_sched: RTL

Multi-channel PWM scheduler that shares one single-port waveform ROM (registered read, 1-cycle latency, e.g. `iob_rom_sp` loaded with a sine table) between `N_CH` independent PWM channels. Each channel runs its own period counter and fetches the next waveform sample once per PWM period. A round-robin arbiter sequences the ROM reads and scales each sample by its channel's period to form a duty value. The block sits between the per-channel period/enable software registers and the `pwm_output` pins, replacing one-ROM-per-channel instantiation.

---
 rtl/iob_pwm_rom_sched_if.sv | 22 ++
 rtl/iob_pwm_rom_sched.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/iob_pwm_rom_sched_if.sv
// Read port of the shared single-port waveform ROM (registered read, 1-cycle latency).
// The scheduler is the master; the ROM is the slave.
interface iob_pwm_rom_sched_if #(
  parameter int unsigned ROM_ADDR_W = 7,
  parameter int unsigned ROM_DATA_W = 16
);
  logic                  rom_r_en;
  logic [ROM_ADDR_W-1:0] rom_addr;
  logic [ROM_DATA_W-1:0] rom_rdata;

  modport master (
    output rom_r_en,
    output rom_addr,
    input  rom_rdata
  );

  modport slave (
    input  rom_r_en,
    input  rom_addr,
    output rom_rdata
  );
endinterface

// File: rtl/iob_pwm_rom_sched.sv
// N_CH PWM channels sharing one waveform ROM. A round-robin arbiter fetches one sample per
// channel period and scales it by that channel's period to form the next duty value.
module iob_pwm_rom_sched #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned PER_W      = 16,
  parameter int unsigned ROM_ADDR_W = 7,
  parameter int unsigned ROM_DATA_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         ch_en,
  input  logic [N_CH*PER_W-1:0]   ch_period,
  input  logic                    ovf_clr,
  iob_pwm_rom_sched_if.master     rom,
  output logic [N_CH-1:0]         pwm_out,
  output logic [N_CH-1:0]         overflow,
  output logic                    busy
);

  localparam int unsigned GW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned MW = ROM_DATA_W + PER_W;
  localparam logic [GW-1:0] LastCh = GW'(N_CH - 1);

  typedef enum logic [1:0] {StIdle, StRead, StCapture} state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;

  logic [PER_W-1:0]      per         [N_CH];
  logic [PER_W-1:0]      cnt_q       [N_CH];
  logic [ROM_ADDR_W-1:0] idx_q       [N_CH];
  logic [PER_W-1:0]      duty_next_q [N_CH];
  logic [PER_W-1:0]      duty_act_q  [N_CH];

  logic [N_CH-1:0] active, active_q, start, wrap, cap, ovf_set;
  logic [N_CH-1:0] pend_q, pwm_q, ovf_q, others;

  logic [PER_W-1:0] per_g;
  logic [MW-1:0]    prod;
  logic [PER_W-1:0] scaled;

  // First requester strictly after the last grant, wrapping around.
  function automatic logic [GW-1:0] rr_pick(input logic [N_CH-1:0] req,
                                            input logic [GW-1:0]   last);
    logic [GW-1:0] pick;
    logic          found;
    int unsigned   c;
    pick  = last;
    found = 1'b0;
    for (int unsigned k = 1; k <= N_CH; k++) begin
      c = (32'(last) + k) % N_CH;
      if (!found && req[GW'(c)]) begin
        pick  = GW'(c);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    for (int i = 0; i < int'(N_CH); i++) begin
      per[i]     = ch_period[i*PER_W +: PER_W];
      active[i]  = ch_en[i] && (per[i] != '0);
      start[i]   = active[i] && !active_q[i];
      // >= rather than == so a live period decrease below cnt still wraps promptly
      wrap[i]    = active[i] && !start[i] && (cnt_q[i] >= per[i] - PER_W'(1));
      cap[i]     = (state_q == StCapture) && (grant_q == GW'(i));
      ovf_set[i] = wrap[i] && pend_q[i] && !cap[i];
    end
  end

  // Full-width product keeps the scaled duty strictly below the period.
  assign per_g  = per[grant_q];
  assign prod   = MW'(rom.rom_rdata) * MW'(per_g);
  assign scaled = prod[ROM_DATA_W +: PER_W];

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rom.rom_r_en = 1'b0;
    rom.rom_addr = '0;
    others       = pend_q & ~(N_CH'(1) << grant_q);
    unique case (state_q)
      StIdle: begin
        if (|pend_q) begin
          grant_d = rr_pick(pend_q, grant_q);
          state_d = StRead;
        end
      end
      StRead: begin
        rom.rom_r_en = 1'b1;
        rom.rom_addr = idx_q[grant_q];
        state_d      = StCapture;
      end
      StCapture: begin
        if (|others) begin
          grant_d = rr_pick(others, grant_q);
          state_d = StRead;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= LastCh;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= '0;
      pend_q   <= '0;
      pwm_q    <= '0;
      ovf_q    <= '0;
      for (int i = 0; i < int'(N_CH); i++) begin
        cnt_q[i]       <= '0;
        idx_q[i]       <= '0;
        duty_next_q[i] <= '0;
        duty_act_q[i]  <= '0;
      end
    end else begin
      active_q <= active;
      ovf_q    <= (ovf_clr ? '0 : ovf_q) | ovf_set;
      for (int i = 0; i < int'(N_CH); i++) begin
        pwm_q[i] <= active[i] && (cnt_q[i] < duty_act_q[i]);
        if (!active[i]) begin
          cnt_q[i]      <= '0;
          idx_q[i]      <= '0;
          pend_q[i]     <= 1'b0;
          duty_act_q[i] <= '0;
        end else if (start[i]) begin
          // Fresh start: state is already zero, request sample 0 right away.
          cnt_q[i]  <= (per[i] == PER_W'(1)) ? '0 : PER_W'(1);
          pend_q[i] <= 1'b1;
        end else begin
          cnt_q[i] <= wrap[i] ? '0 : cnt_q[i] + PER_W'(1);
          if (cap[i]) begin
            duty_next_q[i] <= scaled;
            idx_q[i]       <= idx_q[i] + ROM_ADDR_W'(1);
          end
          if (wrap[i]) begin
            duty_act_q[i] <= duty_next_q[i];
            pend_q[i]     <= 1'b1;
          end else if (cap[i]) begin
            pend_q[i] <= 1'b0;
          end
        end
      end
    end
  end

  assign pwm_out  = pwm_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != StIdle);

endmodule
